audio_sample_packetizer: RTL and testbench

Buffers stereo L-PCM samples arriving at the audio sample rate and groups them into up to four samples per HDMI Audio Sample Packet. It sits directly upstream of `audio_sample_packet` and drives its `frame_counter`, `audio_sample_word` and `audio_sample_word_present` inputs. It also tracks the IEC 60958 192-frame channel-status block position across packets. The data-island scheduler sees `packet_pending` and answers with `packet_req`.

---
 rtl/hdmi_audio_pkg.sv | 32 +++
 rtl/audio_sample_fifo.sv | 55 +++++
 rtl/audio_sample_packetizer.sv | 190 +++++++++++++++++++
 tb/tb_audio_sample_packetizer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared HDMI audio types: IEC 60958 block length, audio word width, stereo
// sample layout, packetizer state encoding and frame-index wrap helper.
// Imported by audio_sample_fifo and audio_sample_packetizer.
package hdmi_audio_pkg;

  localparam int IEC60958_BLOCK_FRAMES = 192;
  localparam int AUDIO_WORD_WIDTH      = 24;

  typedef struct packed {
    logic [23:0] right;
    logic [23:0] left;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_READY = 2'd2
  } pkt_state_t;

  // Advance an IEC 60958 frame index by n (0..4) modulo the 192-frame block.
  // The 9-bit sum cannot exceed 191 + 4, so one conditional subtract suffices.
  function automatic logic [7:0] frame_advance(input logic [7:0] idx,
                                               input logic [2:0] n);
    logic [8:0] sum;
    sum = {1'b0, idx} + {6'd0, n};
    if (sum >= 9'(IEC60958_BLOCK_FRAMES)) begin
      sum = sum - 9'(IEC60958_BLOCK_FRAMES);
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock stereo sample FIFO: one write per cycle, pops 0..4 entries per
// cycle and always presents the four oldest entries on rd_data[0..3].
// Ports: clk_pixel/reset_n (sync, active-low), wr_en/wr_data write side,
// pop_count pop side, rd_data look-ahead window, level occupancy.
// The caller never writes when full and never pops more than level.
module audio_sample_fifo
  import hdmi_audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_pixel,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  stereo_sample_t           wr_data,
  input  logic [2:0]               pop_count,
  output stereo_sample_t           rd_data [4],
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  stereo_sample_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr + AW'(pop_count);
      level  <= level + LW'(wr_en) - LW'(pop_count);
    end
  end

  // Storage needs no reset: entries are only ever read below the level mark.
  always_ff @(posedge clk_pixel) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_data[i] = mem[rd_ptr + AW'(i)];
    end
  end

endmodule

// File: rtl/audio_sample_packetizer.sv
// Groups stereo L-PCM samples into HDMI Audio Sample Packets of up to four
// samples and tracks the IEC 60958 192-frame block index of slot 0.
// Ports: clk_pixel, reset_n (sync, active-low); in_valid/in_left/in_right
// sample input; packet_req from the scheduler; packet_pending, packet_valid,
// frame_counter, audio_sample_word, audio_sample_word_present, level, overflow.
// Macro AUDIO_SAMPLE_PACKETIZER_FLUSH_EN enables the partial-group flush timer.
module audio_sample_packetizer
  import hdmi_audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                           clk_pixel,
  input  logic                           reset_n,
  input  logic                           in_valid,
  input  logic [SAMPLE_WIDTH-1:0]        in_left,
  input  logic [SAMPLE_WIDTH-1:0]        in_right,
  input  logic                           packet_req,
  output logic                           packet_pending,
  output logic                           packet_valid,
  output logic [7:0]                     frame_counter,
  output logic [23:0]                    audio_sample_word [3:0][1:0],
  output logic [3:0]                     audio_sample_word_present,
  output logic [$clog2(FIFO_DEPTH):0]    level,
  output logic                           overflow
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FOUR    = LW'(4);

  stereo_sample_t  wr_data;
  stereo_sample_t  rd_data [4];
  logic            full;
  logic            push;
  logic            pop_ok;
  logic [2:0]      pop_count;
  logic [3:0]      present_mask;
  logic [LW-1:0]   level_next;
  logic            flush_due;
  logic [7:0]      frame_idx;
  pkt_state_t      st;
  pkt_state_t      st_next;

  // Narrow samples are MSB-aligned inside the 24-bit audio word.
  always_comb begin
    wr_data       = '0;
    wr_data.left  = AUDIO_WORD_WIDTH'(in_left)  << (AUDIO_WORD_WIDTH - SAMPLE_WIDTH);
    wr_data.right = AUDIO_WORD_WIDTH'(in_right) << (AUDIO_WORD_WIDTH - SAMPLE_WIDTH);
  end

  assign full   = (level == DEPTH_L);
  assign push   = in_valid && !full;
  assign pop_ok = packet_req && (level != '0);

  // Pop size uses the registered level, so a same-cycle push is never popped.
  always_comb begin
    pop_count = 3'd0;
    if (pop_ok) begin
      pop_count = (level >= FOUR) ? 3'd4 : level[2:0];
    end
  end

  always_comb begin
    case (pop_count)
      3'd1:    present_mask = 4'b0001;
      3'd2:    present_mask = 4'b0011;
      3'd3:    present_mask = 4'b0111;
      3'd4:    present_mask = 4'b1111;
      default: present_mask = 4'b0000;
    endcase
  end

  assign level_next = level + LW'(push) - LW'(pop_count);

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .wr_en     (push),
    .wr_data   (wr_data),
    .pop_count (pop_count),
    .rd_data   (rd_data),
    .level     (level)
  );

`ifdef AUDIO_SAMPLE_PACKETIZER_FLUSH_EN
  localparam int TW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TW-1:0] FLUSH_L = TW'(FLUSH_CYCLES);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          partial;

  assign partial = (level != '0) && (level < FOUR);

  // Ages a partial group; any pop or a full/empty FIFO restarts the count.
  always_comb begin
    timer_next = '0;
    if (partial && !pop_ok) begin
      timer_next = (timer == FLUSH_L) ? timer : timer + TW'(1);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      timer <= '0;
    end else begin
      timer <= timer_next;
    end
  end

  assign flush_due = (timer_next == FLUSH_L);
`else
  assign flush_due = 1'b0;
`endif

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      st <= ST_IDLE;
    end else begin
      st <= st_next;
    end
  end

  // Transitions look at the occupancy after this edge so that pending
  // rises together with the level that justifies it.
  always_comb begin
    st_next = st;
    case (st)
      ST_IDLE: begin
        if (push) begin
          st_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (level_next == '0) begin
          st_next = ST_IDLE;
        end else if ((level_next >= FOUR) || flush_due) begin
          st_next = ST_READY;
        end
      end
      ST_READY: begin
        if (pop_ok) begin
          if (level_next == '0) begin
            st_next = ST_IDLE;
          end else if ((level_next >= FOUR) || flush_due) begin
            st_next = ST_READY;
          end else begin
            st_next = ST_ACCUM;
          end
        end
      end
      default: st_next = ST_IDLE;
    endcase
  end

  assign packet_pending = (st == ST_READY);

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      packet_valid              <= 1'b0;
      overflow                  <= 1'b0;
      frame_counter             <= '0;
      frame_idx                 <= '0;
      audio_sample_word_present <= '0;
      for (int i = 0; i < 4; i++) begin
        audio_sample_word[i][0] <= '0;
        audio_sample_word[i][1] <= '0;
      end
    end else begin
      packet_valid <= pop_ok;
      if (in_valid && full) begin
        overflow <= 1'b1;
      end
      if (pop_ok) begin
        frame_counter             <= frame_idx;
        frame_idx                 <= frame_advance(frame_idx, pop_count);
        audio_sample_word_present <= present_mask;
        for (int i = 0; i < 4; i++) begin
          audio_sample_word[i][0] <= present_mask[i] ? rd_data[i].left  : '0;
          audio_sample_word[i][1] <= present_mask[i] ? rd_data[i].right : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_packetizer.sv
module tb_audio_sample_packetizer;

  localparam int DEPTH = 8;
  localparam int FL    = 16;
`ifdef AUDIO_SAMPLE_PACKETIZER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic [23:0] in_left   = '0;
  logic [23:0] in_right  = '0;
  logic        packet_req = 1'b0;
  logic        packet_pending;
  logic        packet_valid;
  logic [7:0]  frame_counter;
  logic [23:0] word [3:0][1:0];
  logic [3:0]  present;
  logic [3:0]  level;
  logic        overflow;

  audio_sample_packetizer #(
    .SAMPLE_WIDTH (24),
    .FIFO_DEPTH   (DEPTH),
    .FLUSH_CYCLES (FL)
  ) dut (
    .clk_pixel                 (clk_pixel),
    .reset_n                   (reset_n),
    .in_valid                  (in_valid),
    .in_left                   (in_left),
    .in_right                  (in_right),
    .packet_req                (packet_req),
    .packet_pending            (packet_pending),
    .packet_valid              (packet_valid),
    .frame_counter             (frame_counter),
    .audio_sample_word         (word),
    .audio_sample_word_present (present),
    .level                     (level),
    .overflow                  (overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of {left,right} samples plus the packet outputs.
  logic [47:0] q[$];
  int          fidx;
  int          tmr;
  bit          e_ovf;
  bit          e_pv;
  bit          e_pend;
  int          e_fc;
  logic [3:0]  e_pres;
  logic [23:0] e_w [4][2];

  task automatic model_reset();
    q.delete();
    fidx = 0; tmr = 0; e_ovf = 0; e_pv = 0; e_pend = 0; e_fc = 0; e_pres = '0;
    for (int i = 0; i < 4; i++) begin
      e_w[i][0] = '0;
      e_w[i][1] = '0;
    end
  endtask

  task automatic do_reset(input int cycles, input bit v);
    reset_n = 1'b0;
    in_valid = v;
    in_left = 24'hABCDEF;
    in_right = 24'h123456;
    repeat (cycles) @(posedge clk_pixel);
    model_reset();
    #1;
    reset_n = 1'b1;
    in_valid = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the specified rules, settle.
  task automatic cycle(input bit v, input logic [23:0] l, input logic [23:0] r,
                       input bit req);
    int old;
    int n;
    in_valid = v; in_left = l; in_right = r; packet_req = req;
    @(posedge clk_pixel);
    old = q.size();
    e_pv = 1'b0;
    if (req && old > 0) begin
      n = (old < 4) ? old : 4;
      e_pv = 1'b1;
      e_pres = 4'((1 << n) - 1);
      e_fc = fidx;
      fidx = (fidx + n) % 192;
      for (int i = 0; i < 4; i++) begin
        e_w[i][0] = (i < n) ? q[i][47:24] : 24'd0;
        e_w[i][1] = (i < n) ? q[i][23:0]  : 24'd0;
      end
      repeat (n) void'(q.pop_front());
      tmr = 0;
    end else if (old >= 1 && old <= 3) begin
      tmr = (tmr < FL) ? tmr + 1 : FL;
    end else begin
      tmr = 0;
    end
    if (v) begin
      if (old < DEPTH) q.push_back({l, r});
      else e_ovf = 1'b1;
    end
    e_pend = (q.size() >= 4) || (FLUSH_ON && q.size() > 0 && tmr >= FL);
    #1;
    in_valid = 1'b0; packet_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3, 1'b1);
    @(posedge clk_pixel); #1;
    total++;
    if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++;
    if ({packet_pending, packet_valid, overflow} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {packet_pending, packet_valid, overflow});
    end
    total++;
    if (frame_counter !== 8'd0 || present !== 4'd0) begin
      bad++; $display("FAIL reset_fc_present got=%0d/%b want=0/0000", frame_counter, present);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (word[i][0] !== 24'd0 || word[i][1] !== 24'd0) begin
        bad++; $display("FAIL reset_word%0d got=%h/%h want=0/0", i, word[i][0], word[i][1]);
      end
    end
  endtask

  task automatic test_full_packet();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 24'(i), 24'(32'h100000 + i), 1'b0);
      total++;
      if (packet_pending !== (i == 4)) begin
        bad++; $display("FAIL full_pending_after_push%0d got=%b want=%b", i, packet_pending, i == 4);
      end
    end
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (packet_valid !== 1'b1 || present !== 4'b1111) begin
      bad++; $display("FAIL full_pv_present got=%b/%b want=1/1111", packet_valid, present);
    end
    total++;
    if (word[0][0] !== 24'h000001 || word[0][1] !== 24'h100001) begin
      bad++; $display("FAIL full_slot0 got=%h/%h want=000001/100001", word[0][0], word[0][1]);
    end
    total++;
    if (word[3][0] !== 24'h000004 || word[3][1] !== 24'h100004) begin
      bad++; $display("FAIL full_slot3 got=%h/%h want=000004/100004", word[3][0], word[3][1]);
    end
    total++;
    if (frame_counter !== 8'd0) begin bad++; $display("FAIL full_fc0 got=%0d want=0", frame_counter); end
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (frame_counter !== 8'd4) begin bad++; $display("FAIL full_fc4 got=%0d want=4", frame_counter); end
  endtask

  task automatic test_wrap();
    while (fidx != 188) begin
      for (int i = 0; i < 4; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
    end
    cycle(1'b1, 24'h11, 24'h22, 1'b0);
    cycle(1'b1, 24'h33, 24'h44, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (frame_counter !== 8'd188 || present !== 4'b0011) begin
      bad++; $display("FAIL wrap_fc188 got=%0d/%b want=188/0011", frame_counter, present);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (frame_counter !== 8'd190) begin bad++; $display("FAIL wrap_fc190 got=%0d want=190", frame_counter); end
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (frame_counter !== 8'd2) begin bad++; $display("FAIL wrap_fc2 got=%0d want=2", frame_counter); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'(32'h200 + i), 24'(32'h300 + i), 1'b0);
    cycle(1'b1, 24'h0ABCDE, 24'h0FEDCB, 1'b1);
    total++;
    if (level !== 4'd1 || packet_valid !== 1'b1) begin
      bad++; $display("FAIL simul_level_pv got=%0d/%b want=1/1", level, packet_valid);
    end
    total++;
    if (word[0][0] !== 24'h000200 || present !== 4'b1111) begin
      bad++; $display("FAIL simul_data got=%h/%b want=000200/1111", word[0][0], present);
    end
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (word[0][0] !== 24'h0ABCDE || present !== 4'b0001 || word[1][0] !== 24'd0) begin
      bad++; $display("FAIL simul_single got=%h/%b want=0abcde/0001", word[0][0], present);
    end
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (packet_valid !== 1'b0 || level !== 4'd0) begin
      bad++; $display("FAIL empty_req got=%b/%0d want=0/0", packet_valid, level);
    end
    total++;
    if (word[0][0] !== e_w[0][0] || word[0][1] !== e_w[0][1] || present !== e_pres
        || frame_counter !== 8'(e_fc)) begin
      bad++; $display("FAIL empty_hold got=%h/%b/%0d want=%h/%b/%0d", word[0][0], present,
                      frame_counter, e_w[0][0], e_pres, e_fc);
    end
  endtask

  task automatic test_flush();
    int first;
    int start_idx;
    first = -1;
    start_idx = fidx;
    cycle(1'b1, 24'h0F0F0F, 24'h0E0E0E, 1'b0);
    cycle(1'b1, 24'h0D0D0D, 24'h0C0C0C, 1'b0);
    for (int c = 0; c < 2 * FL + 4; c++) begin
      cycle(1'b0, '0, '0, 1'b0);
      total++;
      if (packet_pending !== e_pend) begin
        bad++; $display("FAIL flush_pending_c%0d got=%b want=%b", c, packet_pending, e_pend);
      end
      if (packet_pending === 1'b1 && first < 0) first = c;
    end
    total++;
    if ((first >= 0) !== FLUSH_ON || (FLUSH_ON && first < FL - 2)) begin
      bad++; $display("FAIL flush_timing got=%0d want_flush=%b", first, FLUSH_ON);
    end
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (present !== 4'b0011 || word[2][0] !== 24'd0 || word[3][1] !== 24'd0
        || word[1][0] !== 24'h0D0D0D) begin
      bad++; $display("FAIL flush_data got=%b/%h want=0011/0d0d0d", present, word[1][0]);
    end
    total++;
    if (fidx != (start_idx + 2) % 192 || frame_counter !== 8'(start_idx)) begin
      bad++; $display("FAIL flush_fc got=%0d want=%0d", frame_counter, start_idx);
    end
  endtask

  task automatic test_random();
    bit v;
    bit r;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 99) < 45);
      r = ($urandom_range(0, 99) < 30);
      cycle(v, 24'($urandom), 24'($urandom), r);
      total++;
      if (level !== 4'(q.size())) begin
        bad++; $display("FAIL rand_level c=%0d got=%0d want=%0d", c, level, q.size());
      end
      total++;
      if ({packet_pending, packet_valid, overflow} !== {e_pend, e_pv, e_ovf}) begin
        bad++; $display("FAIL rand_flags c=%0d got=%b want=%b", c,
                        {packet_pending, packet_valid, overflow}, {e_pend, e_pv, e_ovf});
      end
      total++;
      if (frame_counter !== 8'(e_fc) || present !== e_pres) begin
        bad++; $display("FAIL rand_fc c=%0d got=%0d/%b want=%0d/%b", c, frame_counter, present,
                        e_fc, e_pres);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (word[i][0] !== e_w[i][0] || word[i][1] !== e_w[i][1]) begin
          bad++; $display("FAIL rand_word%0d c=%0d got=%h/%h want=%h/%h", i, c, word[i][0],
                          word[i][1], e_w[i][0], e_w[i][1]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(1, 1'b0);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", overflow); end
    for (int i = 1; i <= 9; i++) cycle(1'b1, 24'(i), 24'(32'h100000 + i), 1'b0);
    total++;
    if (overflow !== 1'b1 || level !== 4'd8) begin
      bad++; $display("FAIL ovf_set got=%b/%0d want=1/8", overflow, level);
    end
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (word[0][0] !== 24'd1 || word[3][0] !== 24'd4) begin
      bad++; $display("FAIL ovf_pkt1 got=%h..%h want=000001..000004", word[0][0], word[3][0]);
    end
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (word[0][0] !== 24'd5 || word[3][0] !== 24'd8 || word[3][1] !== 24'h100008) begin
      bad++; $display("FAIL ovf_pkt2 got=%h..%h want=000005..000008", word[0][0], word[3][0]);
    end
    total++;
    if (level !== 4'd0 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_drained got=%0d/%b want=0/1", level, overflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 24'($urandom), 24'($urandom), 1'b0);
    do_reset(1, 1'b1);
    total++;
    if (level !== 4'd0 || overflow !== 1'b0 || frame_counter !== 8'd0) begin
      bad++; $display("FAIL mid_reset got=%0d/%b/%0d want=0/0/0", level, overflow, frame_counter);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'(32'h777 + i), 24'(32'h888 + i), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    total++;
    if (frame_counter !== 8'd0 || word[0][0] !== 24'h000777) begin
      bad++; $display("FAIL mid_restart got=%0d/%h want=0/000777", frame_counter, word[0][0]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_packet();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
